quad_count_scheduler: RTL and testbench

QUAD_COUNT_SCHEDULER -- requirements
Module: quad_count_scheduler

---
 rtl/quad_count_scheduler.sv | 93 +++++++++
 tb/tb_quad_count_scheduler.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_count_scheduler.sv
// Two-requester round-robin front end for a shared quadruple-counter datapath.
// Holds each job for SETTLE cycles, captures the count and hands it back with its owner's id.
`timescale 1ns/1ps
module quad_count_scheduler #(
  parameter int unsigned N      = 100,
  parameter int unsigned KW     = 8,
  parameter int unsigned CW     = 16,
  parameter int unsigned SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_array,
  input  logic [KW-1:0] req0_k,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_array,
  input  logic [KW-1:0] req1_k,
  output logic [N-1:0]  dp_array,
  output logic [KW-1:0] dp_k,
  input  logic [CW-1:0] dp_count,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [CW-1:0] rsp_count,
  output logic          busy,
  output logic [15:0]   jobs_done
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t     state;
  logic       last_grant;
  logic [3:0] settle_cnt;
  logic       win;

  // A lone requester always wins; otherwise the one not served last is offered.
  always_comb begin
    win = ~last_grant;
    if (req0_valid && !req1_valid)      win = 1'b0;
    else if (req1_valid && !req0_valid) win = 1'b1;
  end

  assign req0_ready = (state == IDLE) && !win;
  assign req1_ready = (state == IDLE) &&  win;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      settle_cnt <= '0;
      dp_array   <= '0;
      dp_k       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_count  <= '0;
      jobs_done  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((req0_valid && !win) || (req1_valid && win)) begin
            dp_array   <= win ? req1_array : req0_array;
            dp_k       <= win ? req1_k     : req0_k;
            rsp_id     <= win;
            last_grant <= win;
            settle_cnt <= 4'(SETTLE - 1);
            state      <= RUN;
          end
        end
        RUN: begin
          if (settle_cnt == '0) begin
            rsp_count <= dp_count;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            jobs_done <= jobs_done + 16'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quad_count_scheduler.sv
// Directed bench for quad_count_scheduler with a scoreboard of expected responses
// and an arithmetic stub standing in for the counting datapath.
`timescale 1ns/1ps
module tb_quad_count_scheduler;
  localparam int N = 100, KW = 8, CW = 16, SETTLE = 2;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [N-1:0]  req0_array, req1_array, dp_array;
  logic [KW-1:0] req0_k, req1_k, dp_k;
  logic [CW-1:0] dp_count, rsp_count;
  logic          rsp_valid, rsp_ready, rsp_id, busy;
  logic [15:0]   jobs_done;

  quad_count_scheduler #(.N(N), .KW(KW), .CW(CW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_array(req0_array), .req0_k(req0_k),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_array(req1_array), .req1_k(req1_k),
    .dp_array(dp_array), .dp_k(dp_k), .dp_count(dp_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .busy(busy), .jobs_done(jobs_done)
  );

  function automatic logic [15:0] stub(input logic [N-1:0] a, input logic [KW-1:0] k);
    return 16'($countones(a)) + 16'(k) - 16'd2;
  endfunction

  assign dp_count = stub(dp_array, dp_k);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed {logic id; logic [15:0] cnt;} exp_t;
  exp_t exp_q[$];
  int   total = 0, bad = 0;
  logic exp_last = 1'b1;
  int   acc_cyc = 0, prev_cyc = 0;
  bit   acc;
  exp_t held;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called just before an edge: predicts the arbitration winner and queues its result.
  task automatic offer(input string tag, output bit accepted);
    logic w;
    exp_t e;
    #1;
    if (req0_valid && !req1_valid)      w = 1'b0;
    else if (req1_valid && !req0_valid) w = 1'b1;
    else                                w = ~exp_last;
    chk({tag, "_rdy0"}, req0_ready, !w);
    chk({tag, "_rdy1"}, req1_ready, w);
    accepted = w ? req1_valid : req0_valid;
    if (accepted) begin
      e.id  = w;
      e.cnt = w ? stub(req1_array, req1_k) : stub(req0_array, req0_k);
      exp_q.push_back(e);
      exp_last = w;
      prev_cyc = acc_cyc;
      acc_cyc  = cyc;
    end
  endtask

  task automatic expect_rsp(input string tag, output exp_t e);
    int n = 0;
    e = '0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk({tag, "_lat"}, cyc - acc_cyc, SETTLE + 1);
    chk({tag, "_qsz"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_id"},  rsp_id,    e.id);
      chk({tag, "_cnt"}, rsp_count, e.cnt);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rdy0"}, req0_ready, 1);
    chk({tag, "_rdy1"}, req1_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rv"},   rsp_valid, 0);
    chk({tag, "_rid"},  rsp_id, 0);
    chk({tag, "_rcnt"}, rsp_count, 0);
    chk({tag, "_jd"},   jobs_done, 0);
    chk({tag, "_dpa"},  dp_array, 0);
    chk({tag, "_dpk"},  dp_k, 0);
  endtask

  task automatic do_reset(input string tag);
    req0_valid = 0; req1_valid = 0;
    rst_n = 0;
    #1;
    reset_checks(tag);
    exp_q.delete();
    exp_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_array = '0; req1_array = '0; req0_k = '0; req1_k = '0;
    #1;
    do_reset("rst0");

    // Single job from requester 0
    req0_valid = 1; req0_array = 100'hF; req0_k = 8'd3; rsp_ready = 1;
    offer("single", acc);
    @(negedge clk);
    req0_valid = 0;
    chk("single_dpa", dp_array, 100'hF);
    chk("single_dpk", dp_k, 3);
    chk("single_busy", busy, 1);
    chk("single_rdy0_run", req0_ready, 0);
    chk("single_rdy1_run", req1_ready, 0);
    expect_rsp("single", held);
    chk("single_cnt5", rsp_count, 16'd5);
    @(negedge clk);
    chk("single_rv_clr", rsp_valid, 0);
    chk("single_jd", jobs_done, 1);
    chk("single_idle", busy, 0);

    // Contention: both valid, grants alternate starting from requester 0
    do_reset("rst1");
    req0_valid = 1; req0_array = 100'h3;    req0_k = 8'd10;
    req1_valid = 1; req1_array = 100'hFF00; req1_k = 8'd20;
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      offer("cont", acc);
      if (i > 0) chk("cont_period", acc_cyc - prev_cyc, SETTLE + 2);
      @(negedge clk);
      chk("cont_rdy0_run", req0_ready, 0);
      chk("cont_rdy1_run", req1_ready, 0);
      expect_rsp("cont", held);
      @(negedge clk);
      chk("cont_rv_clr", rsp_valid, 0);
    end
    chk("cont_jd", jobs_done, 4);

    // Backpressure: response held for 10 cycles, requesters kept waiting
    req1_valid = 0; req0_array = 100'h1234; req0_k = 8'd40; rsp_ready = 0;
    offer("bp", acc);
    @(negedge clk);
    req1_valid = 1; req1_array = 100'h7; req1_k = 8'd1;
    expect_rsp("bp", held);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rv_hold",  rsp_valid, 1);
      chk("bp_cnt_hold", rsp_count, held.cnt);
      chk("bp_id_hold",  rsp_id, held.id);
      chk("bp_rdy0",     req0_ready, 0);
      chk("bp_rdy1",     req1_ready, 0);
      chk("bp_busy",     busy, 1);
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_rv_clr", rsp_valid, 0);
    chk("bp_jd", jobs_done, 5);
    offer("bp_next", acc);
    @(negedge clk);
    chk("bp_next_dpa", dp_array, 100'h7);
    expect_rsp("bp_next", held);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;

    // Input isolation: requester inputs change after accept
    req0_valid = 1; req0_array = 100'hABC; req0_k = 8'd7;
    offer("iso", acc);
    @(negedge clk);
    req0_valid = 0; req0_array = 100'h5555_5555; req0_k = 8'd99;
    chk("iso_dpa_run", dp_array, 100'hABC);
    chk("iso_dpk_run", dp_k, 7);
    expect_rsp("iso", held);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("iso_dpa_idle", dp_array, 100'hABC);
      chk("iso_dpk_idle", dp_k, 7);
      chk("iso_jd_idle",  jobs_done, 7);
    end
    req0_valid = 1;
    offer("iso2", acc);
    @(negedge clk);
    req0_valid = 0;
    chk("iso2_dpa", dp_array, 100'h5555_5555);
    chk("iso2_dpk", dp_k, 99);
    expect_rsp("iso2", held);
    @(negedge clk);

    // Reset one cycle after accept aborts the job
    req1_valid = 1; req1_array = 100'hF0; req1_k = 8'd2;
    offer("mrst", acc);
    @(negedge clk);
    req1_valid = 0;
    rst_n = 0;
    #1;
    reset_checks("mrst");
    exp_q.delete();
    exp_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mrst_rv", rsp_valid, 0);
    end
    rst_n = 1;
    #1;
    chk("mrst_rel_rdy0", req0_ready, 1);
    chk("mrst_rel_busy", busy, 0);

    // Counter wrap
    @(negedge clk);
    force dut.jobs_done = 16'hFFFF;
    @(negedge clk);
    release dut.jobs_done;
    req1_valid = 1; req1_array = 100'h1; req1_k = 8'd9;
    offer("wrap", acc);
    @(negedge clk);
    req1_valid = 0;
    expect_rsp("wrap", held);
    @(negedge clk);
    chk("wrap_jd", jobs_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
